gt_rx_word_align: RTL and testbench

RX-side stage directly downstream of the GT channel, in the RX user clock domain (rxusrclk2). It takes the 32-bit rxdata/rxcharisk word, whose K28.5 comma can land in any of the 4 byte lanes. It finds the comma lane, confirms it is stable, and rotates the byte stream so every comma word presents the comma in byte 0. Downstream framing logic receives lane-aligned words with a valid/lock indication.

---
 rtl/gt_rx_word_align.sv | 176 +++++++++++++++++
 tb/tb_gt_rx_word_align.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gt_rx_word_align.sv
// RX word aligner for a 32-bit GT interface.
// Locates the K28.5 comma lane, qualifies it, and rotates the byte stream so commas land in byte 0.
module gt_rx_word_align #(
  parameter logic [7:0]  COMMA_BYTE   = 8'hBC,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_gt_aligned,
  input  logic [31:0] i_rxdata,
  input  logic [3:0]  i_rxcharisk,
  output logic [31:0] o_data,
  output logic [3:0]  o_charisk,
  output logic        o_valid,
  output logic        o_lock,
  output logic [1:0]  o_offset
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic        rst;
  logic [3:0]  lane_hit;
  logic        det_hit;
  logic [1:0]  det_off;
  logic [1:0]  cand_q, cand_d;
  logic [1:0]  app_q, app_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  miss_q, miss_d;
  logic [3:0]  cnt_inc, miss_inc;
  logic [31:0] prev_data_q, data_q, data_d;
  logic [3:0]  prev_k_q, k_q, k_d;

  // Assertion is immediate; release is retimed through two flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rst_sync_q <= '1;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  always_comb begin
    det_hit = 1'b0;
    det_off = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_hit[i] = i_rxcharisk[i] && (i_rxdata[8*i +: 8] == COMMA_BYTE);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane_hit[i] && !det_hit) begin
        det_hit = 1'b1;
        det_off = i[1:0];
      end
    end
  end

  // Rotation spans the previous and current word, giving a fixed two-cycle latency.
  always_comb begin
    data_d = prev_data_q;
    k_d    = prev_k_q;
    case (app_q)
      2'd1: begin
        data_d = {i_rxdata[7:0], prev_data_q[31:8]};
        k_d    = {i_rxcharisk[0], prev_k_q[3:1]};
      end
      2'd2: begin
        data_d = {i_rxdata[15:0], prev_data_q[31:16]};
        k_d    = {i_rxcharisk[1:0], prev_k_q[3:2]};
      end
      2'd3: begin
        data_d = {i_rxdata[23:0], prev_data_q[31:24]};
        k_d    = {i_rxcharisk[2:0], prev_k_q[3]};
      end
      default: ;
    endcase
  end

  assign cnt_inc  = (cnt_q  == 4'hF) ? cnt_q  : cnt_q  + 4'd1;
  assign miss_inc = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    app_d   = app_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    off_d   = off_q;
    if (!i_gt_aligned) begin
      state_d = HUNT;
      cnt_d   = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (det_hit) begin
            cand_d = det_off;
            cnt_d  = 4'd1;
            miss_d = '0;
            if (LOCK_COUNT == 1) begin
              state_d = LOCKED;
              app_d   = det_off;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (det_hit) begin
            if (det_off == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc >= 4'(LOCK_COUNT)) begin
                state_d = LOCKED;
                app_d   = cand_q;
                miss_d  = '0;
              end
            end else begin
              cand_d = det_off;
              cnt_d  = 4'd1;
            end
          end
        end
        LOCKED: begin
          if (det_hit) begin
            if (det_off == app_q) begin
              miss_d = '0;
            end else begin
              miss_d = miss_inc;
              if (miss_inc >= 4'(UNLOCK_COUNT)) begin
                state_d = HUNT;
                cnt_d   = '0;
                miss_d  = '0;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (state_d == VERIFY)      off_d = cand_d;
    else if (state_d == LOCKED) off_d = app_d;
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      cand_q      <= '0;
      app_q       <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      miss_q      <= '0;
      prev_data_q <= '0;
      prev_k_q    <= '0;
      data_q      <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      app_q       <= app_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      prev_data_q <= i_rxdata;
      prev_k_q    <= i_rxcharisk;
      data_q      <= data_d;
      k_q         <= k_d;
    end
  end

  assign o_data    = data_q;
  assign o_charisk = k_q;
  assign o_lock    = (state_q == LOCKED);
  assign o_valid   = (state_q == LOCKED);
  assign o_offset  = off_q;

endmodule

// File: tb/tb_gt_rx_word_align.sv
// Bench for gt_rx_word_align: directed scenarios plus random traffic against a byte-stream reference model.
module tb_gt_rx_word_align;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_gt_aligned = 1'b0;
  logic [31:0] i_rxdata = '0;
  logic [3:0]  i_rxcharisk = '0;
  logic [31:0] o_data;
  logic [3:0]  o_charisk;
  logic        o_valid, o_lock;
  logic [1:0]  o_offset;

  int total = 0;
  int bad   = 0;

  gt_rx_word_align #(
    .COMMA_BYTE(8'hBC),
    .LOCK_COUNT(4),
    .UNLOCK_COUNT(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_gt_aligned(i_gt_aligned),
    .i_rxdata(i_rxdata), .i_rxcharisk(i_rxcharisk),
    .o_data(o_data), .o_charisk(o_charisk), .o_valid(o_valid),
    .o_lock(o_lock), .o_offset(o_offset)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: byte stream view plus comma bookkeeping.
  logic [31:0] m_prev_d, m_out_d;
  logic [3:0]  m_prev_k, m_out_k;
  bit          m_lock, m_verify;
  int          m_cand, m_app, m_off, m_cnt, m_miss, m_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_prev_d = '0; m_prev_k = '0; m_out_d = '0; m_out_k = '0;
    m_lock = 0; m_verify = 0;
    m_cand = 0; m_app = 0; m_off = 0; m_cnt = 0; m_miss = 0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic [3:0] k, input logic al, input logic rs);
    int lane;
    if (rs || m_hold > 0) begin
      model_zero();
      m_hold = rs ? 2 : m_hold - 1;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      int idx;
      idx = b + m_app;
      if (idx < 4) begin
        m_out_d[8*b +: 8] = m_prev_d[8*idx +: 8];
        m_out_k[b]        = m_prev_k[idx];
      end else begin
        m_out_d[8*b +: 8] = d[8*(idx-4) +: 8];
        m_out_k[b]        = k[idx-4];
      end
    end
    m_prev_d = d;
    m_prev_k = k;
    lane = -1;
    for (int b = 3; b >= 0; b--)
      if (k[b] && d[8*b +: 8] == 8'hBC) lane = b;
    if (!al) begin
      m_lock = 0; m_verify = 0; m_cnt = 0; m_miss = 0;
    end else if (m_lock) begin
      if (lane >= 0) begin
        if (lane == m_app) m_miss = 0;
        else begin
          m_miss = (m_miss < 15) ? m_miss + 1 : 15;
          if (m_miss >= 8) begin
            m_lock = 0; m_cnt = 0; m_miss = 0;
          end
        end
      end
    end else if (lane >= 0) begin
      if (m_verify && lane == m_cand) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else begin
        m_cand = lane; m_cnt = 1; m_verify = 1;
      end
      if (m_cnt >= 4) begin
        m_lock = 1; m_verify = 0; m_app = m_cand; m_miss = 0;
      end
    end
    if (m_lock)        m_off = m_app;
    else if (m_verify) m_off = m_cand;
  endtask

  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic al);
    i_rxdata = d; i_rxcharisk = k; i_gt_aligned = al;
    @(posedge i_clk);
    #1;
    model_step(d, k, al, i_rst);
    chk("data",   o_data,    m_out_d);
    chk("charisk",{28'd0, o_charisk}, {28'd0, m_out_k});
    chk("valid",  {31'd0, o_valid},   {31'd0, m_lock});
    chk("lock",   {31'd0, o_lock},    {31'd0, m_lock});
    chk("offset", {30'd0, o_offset},  32'(m_off));
  endtask

  task automatic comma(input int lane);
    logic [31:0] d;
    logic [3:0]  k;
    d = 32'h0;
    k = 4'b0;
    d[8*lane +: 8] = 8'hBC;
    k[lane] = 1'b1;
    cyc(d, k, 1'b1);
  endtask

  initial begin
    m_hold = 2;
    model_zero();
    repeat (3) cyc('0, '0, 1'b0);
    i_rst = 1'b0;
    repeat (3) cyc('0, '0, 1'b0);
    chk("reset_lock", {31'd0, o_lock}, 32'd0);

    // Offset 0, comma every fourth word.
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) cyc(32'h030201BC, 4'b0001, 1'b1);
      else            cyc(32'h07060504, 4'b0000, 1'b1);
      if (i == 11) chk("t1_prelock", {31'd0, o_lock}, 32'd0);
      if (i == 12) chk("t1_lock", {31'd0, o_lock}, 32'd1);
      if (i == 13) chk("t1_word", o_data, 32'h030201BC);
    end
    cyc('0, '0, 1'b0);

    // Offset 2.
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) cyc(32'h11BC5050, 4'b0100, 1'b1);
      else            cyc(32'h44332222, 4'b0000, 1'b1);
      if (i == 9) begin
        chk("t2_word", o_data, 32'h222211BC);
        chk("t2_k", {28'd0, o_charisk}, 32'h1);
        chk("t2_off", {30'd0, o_offset}, 32'd2);
      end
    end
    cyc('0, '0, 1'b0);

    // Lane change while verifying.
    repeat (3) comma(1);
    chk("t3_off1", {30'd0, o_offset}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      comma(3);
      if (i == 0) chk("t3_off3", {30'd0, o_offset}, 32'd3);
      if (i == 2) chk("t3_nolock", {31'd0, o_lock}, 32'd0);
    end
    chk("t3_lock", {31'd0, o_lock}, 32'd1);
    cyc('0, '0, 1'b0);

    // Unlock on wrong-lane commas.
    repeat (4) comma(0);
    repeat (7) comma(2);
    comma(0);
    chk("t4_keep", {31'd0, o_lock}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      comma(2);
      if (i == 6) chk("t4_still", {31'd0, o_lock}, 32'd1);
    end
    chk("t4_unlock", {31'd0, o_valid}, 32'd0);
    cyc('0, '0, 1'b0);

    // Alignment loss while locked.
    repeat (4) comma(0);
    cyc(32'h12345678, 4'b0000, 1'b0);
    chk("t5_drop", {31'd0, o_valid}, 32'd0);
    repeat (3) comma(0);
    chk("t5_nolock", {31'd0, o_lock}, 32'd0);
    comma(0);
    chk("t5_relock", {31'd0, o_lock}, 32'd1);
    cyc('0, '0, 1'b0);

    // Asynchronous reset in the middle of verification.
    repeat (3) comma(0);
    #3 i_rst = 1'b1;
    #1;
    model_zero();
    m_hold = 2;
    chk("t6_data", o_data, 32'd0);
    chk("t6_k", {28'd0, o_charisk}, 32'd0);
    chk("t6_lock", {31'd0, o_lock}, 32'd0);
    chk("t6_valid", {31'd0, o_valid}, 32'd0);
    chk("t6_off", {30'd0, o_offset}, 32'd0);
    cyc('0, '0, 1'b1);
    i_rst = 1'b0;
    repeat (3) cyc('0, '0, 1'b1);
    comma(0);
    repeat (3) cyc(32'h55555555, 4'b0000, 1'b1);
    chk("t6_nolock", {31'd0, o_lock}, 32'd0);
    repeat (3) comma(0);
    chk("t6_relock", {31'd0, o_lock}, 32'd1);

    // Random traffic.
    begin
      int seg_lane;
      seg_lane = 0;
      for (int n = 0; n < 3000; n++) begin
        logic [31:0] d;
        logic [3:0]  k;
        logic        al;
        int          r, lane;
        if (n % 200 == 0) seg_lane = int'($urandom_range(3, 0));
        d = $urandom;
        k = 4'b0;
        al = ($urandom_range(63, 0) != 0);
        r = int'($urandom_range(7, 0));
        if (r < 3) begin
          lane = ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : seg_lane;
          d[8*lane +: 8] = 8'hBC;
          k[lane] = 1'b1;
        end
        if ($urandom_range(15, 0) == 0) k[$urandom_range(3, 0)] = 1'b1;
        cyc(d, k, al);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
